qracc_output_collector: RTL and testbench

- Downstream of the sequential MAC accumulator; captures each completed output row (all columns' rounded results) on its single-cycle valid pulse.
- The accumulator has no backpressure, so rows are buffered in a small FIFO.
- Rows are then serialized onto a narrower valid/ready bus toward the output SRAM/writeback path.
- Drops and overflow are flagged so the controller can throttle MAC issue.

---
 rtl/qracc_pkg.sv | 12 +
 rtl/qracc_output_collector_if.sv | 14 +
 rtl/qracc_row_fifo.sv | 57 +++++
 rtl/qracc_output_collector.sv | 91 +++++++++
 tb/tb_qracc_output_collector.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/qracc_pkg.sv
// Shared constants and types for the QRACC output path.
// Default sizes: 32 columns x 4 bits per row, serialized over a 32-bit bus.
package qracc_pkg;
   localparam int QRACC_OUT_ELEMENTS   = 32;
   localparam int QRACC_OUT_BITS       = 4;
   localparam int QRACC_OUT_BUS_WIDTH  = 32;
   localparam int QRACC_OUT_FIFO_DEPTH = 4;
   localparam int QRACC_OUT_NUM_BEATS  = QRACC_OUT_ELEMENTS * QRACC_OUT_BITS / QRACC_OUT_BUS_WIDTH;
   localparam int QRACC_OUT_CFG_W      = $clog2(QRACC_OUT_NUM_BEATS + 1);

   typedef logic [QRACC_OUT_CFG_W-1:0] out_beat_cfg_t;
endpackage

// File: rtl/qracc_output_collector_if.sv
// Beat-serial valid/ready bus from the output collector toward writeback.
interface qracc_output_collector_if
   import qracc_pkg::*;
#(
   parameter int busWidth = QRACC_OUT_BUS_WIDTH
);
   logic [busWidth-1:0] data;
   logic                valid;
   logic                ready;
   logic                last;

   modport master (output data, output valid, output last, input ready);
   modport slave  (input data, input valid, input last, output ready);
endinterface

// File: rtl/qracc_row_fifo.sv
// Generic synchronous FIFO with wrap-bit pointers, flush and occupancy count.
// Storage is not reset; only the pointers are.
module qracc_row_fifo
   import qracc_pkg::*;
#(
   parameter int WIDTH = QRACC_OUT_ELEMENTS * QRACC_OUT_BITS,
   parameter int DEPTH = QRACC_OUT_FIFO_DEPTH,
   localparam int AW = $clog2(DEPTH),
   localparam int CW = $clog2(DEPTH + 1)
)(
   input  logic             clk,
   input  logic             nrst,
   input  logic             flush_i,
   input  logic             push_i,
   input  logic [WIDTH-1:0] push_data_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] head_data_o,
   output logic             full_o,
   output logic             empty_o,
   output logic [CW-1:0]    count_o
);
   logic [AW:0]      wr_ptr_q, wr_ptr_d;
   logic [AW:0]      rd_ptr_q, rd_ptr_d;
   logic [WIDTH-1:0] mem_q [DEPTH];

   assign empty_o     = (wr_ptr_q == rd_ptr_q);
   assign full_o      = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
   assign count_o     = wr_ptr_q - rd_ptr_q;
   assign head_data_o = mem_q[rd_ptr_q[AW-1:0]];

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (flush_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
      end else begin
         if (push_i) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
         if (pop_i)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
      end
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // A push into a full FIFO lands on the slot being popped this same cycle.
   always_ff @(posedge clk) begin
      if (push_i && !flush_i) mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
   end
endmodule

// File: rtl/qracc_output_collector.sv
// Buffers completed MAC rows and serializes them as bus-width beats with
// a programmable beat count per row; tracks dropped rows as sticky overflow.
module qracc_output_collector
   import qracc_pkg::*;
#(
   parameter int outputElements = QRACC_OUT_ELEMENTS,
   parameter int outputBits     = QRACC_OUT_BITS,
   parameter int busWidth       = QRACC_OUT_BUS_WIDTH,
   parameter int fifoDepth      = QRACC_OUT_FIFO_DEPTH,
   localparam int numBeats = outputElements * outputBits / busWidth,
   localparam int RowW     = outputElements * outputBits,
   localparam int CfgW     = $clog2(numBeats + 1),
   localparam int CntW     = $clog2(fifoDepth + 1)
)(
   input  logic                     clk,
   input  logic                     nrst,
   input  logic                     clear_i,
   input  logic [CfgW-1:0]          cfg_active_beats_i,
   input  logic                     mac_valid_i,
   input  logic [RowW-1:0]          mac_data_i,
   qracc_output_collector_if.master out_bus,
   output logic                     full_o,
   output logic [CntW-1:0]          count_o,
   output logic                     idle_o,
   output logic                     overflow_o
);
   logic [RowW-1:0] head_row;
   logic            fifo_empty, fifo_full;
   logic [CfgW-1:0] beat_q, beat_d, active_beats;
   logic            overflow_q, overflow_d;
   logic            hs, pop, push, drop;
   logic [31:0]     beat_base;

   function automatic logic [CfgW-1:0] clamp_beats(input logic [CfgW-1:0] cfg);
      if (cfg == '0 || int'(cfg) > numBeats) return CfgW'(numBeats);
      return cfg;
   endfunction

   assign active_beats  = clamp_beats(cfg_active_beats_i);
   assign out_bus.valid = !fifo_empty;
   assign out_bus.last  = out_bus.valid && (beat_q == active_beats - CfgW'(1));
   assign beat_base     = 32'(beat_q) * 32'(busWidth);
   // Gated by valid so the bus reads zero whenever no row is held.
   assign out_bus.data  = out_bus.valid ? head_row[beat_base +: busWidth] : '0;

   assign hs   = out_bus.valid && out_bus.ready;
   assign pop  = hs && out_bus.last;
   assign push = mac_valid_i && !clear_i && (!fifo_full || pop);
   assign drop = mac_valid_i && !clear_i && fifo_full && !pop;

   always_comb begin
      beat_d = beat_q;
      if (clear_i || pop) beat_d = '0;
      else if (hs)        beat_d = beat_q + CfgW'(1);
   end

   assign overflow_d = clear_i ? 1'b0 : (overflow_q || drop);

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         beat_q     <= '0;
         overflow_q <= 1'b0;
      end else begin
         beat_q     <= beat_d;
         overflow_q <= overflow_d;
      end
   end

   qracc_row_fifo #(.WIDTH(RowW), .DEPTH(fifoDepth)) u_row_fifo (
      .clk         (clk),
      .nrst        (nrst),
      .flush_i     (clear_i),
      .push_i      (push),
      .push_data_i (mac_data_i),
      .pop_i       (pop),
      .head_data_o (head_row),
      .full_o      (fifo_full),
      .empty_o     (fifo_empty),
      .count_o     (count_o)
   );

   assign full_o     = fifo_full;
   assign idle_o     = fifo_empty && (beat_q == '0);
   assign overflow_o = overflow_q;

`ifndef SYNTHESIS
   // The beat count is only safe to retune while nothing is buffered or mid-row.
   a_cfg_quasi_static : assert property (@(posedge clk) disable iff (!nrst)
      $changed(cfg_active_beats_i) |-> idle_o);
`endif
endmodule

// File: tb/tb_qracc_output_collector.sv
// Directed bench for qracc_output_collector: beat order, backpressure,
// overflow, full-with-pop, beat clamp, async reset and flush.
module tb_qracc_output_collector;
   import qracc_pkg::*;

   logic          clk = 1'b0;
   logic          nrst;
   logic          clear_i;
   out_beat_cfg_t cfg_active_beats_i;
   logic          mac_valid_i;
   logic [127:0]  mac_data_i;
   logic          full_o;
   logic [2:0]    count_o;
   logic          idle_o;
   logic          overflow_o;

   int n_cmp = 0;
   int n_err = 0;

   qracc_output_collector_if #(.busWidth(32)) bus ();

   qracc_output_collector dut (
      .clk                (clk),
      .nrst               (nrst),
      .clear_i            (clear_i),
      .cfg_active_beats_i (cfg_active_beats_i),
      .mac_valid_i        (mac_valid_i),
      .mac_data_i         (mac_data_i),
      .out_bus            (bus),
      .full_o             (full_o),
      .count_o            (count_o),
      .idle_o             (idle_o),
      .overflow_o         (overflow_o)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [127:0] mk_row(input int r);
      logic [127:0] row;
      for (int b = 0; b < 4; b++) row[b*32 +: 32] = {8'hC0 | 8'(r), 20'hA5A5A, 4'(b)};
      return row;
   endfunction

   task automatic push_row(input logic [127:0] row);
      mac_valid_i = 1'b1;
      mac_data_i  = row;
      @(negedge clk);
      mac_valid_i = 1'b0;
   endtask

   task automatic drain_row(input logic [127:0] row, input int nb, input string tag);
      for (int b = 0; b < nb; b++) begin
         check_eq($sformatf("%s_valid_b%0d", tag, b), 64'(bus.valid), 64'd1);
         check_eq($sformatf("%s_data_b%0d", tag, b), 64'(bus.data), 64'(row[b*32 +: 32]));
         check_eq($sformatf("%s_last_b%0d", tag, b), 64'(bus.last), 64'(b == nb - 1));
         @(negedge clk);
      end
   endtask

   task automatic check_reset_state(input string tag);
      check_eq({tag, "_valid"},    64'(bus.valid),  64'd0);
      check_eq({tag, "_last"},     64'(bus.last),   64'd0);
      check_eq({tag, "_data"},     64'(bus.data),   64'd0);
      check_eq({tag, "_count"},    64'(count_o),    64'd0);
      check_eq({tag, "_full"},     64'(full_o),     64'd0);
      check_eq({tag, "_overflow"}, 64'(overflow_o), 64'd0);
      check_eq({tag, "_idle"},     64'(idle_o),     64'd1);
   endtask

   logic [127:0] row_a;
   logic [31:0]  exp_a [4];
   logic [127:0] row_b;
   int           k;

   initial begin
      nrst = 1'b0; clear_i = 1'b0; cfg_active_beats_i = '0;
      mac_valid_i = 1'b0; mac_data_i = '0; bus.ready = 1'b0;
      repeat (3) @(negedge clk);
      check_reset_state("rst");
      nrst = 1'b1;
      @(negedge clk);

      // Single row, back-to-back beats
      row_a = 128'h76543210_FEDCBA98_01234567_89ABCDEF;
      exp_a[0] = 32'h89ABCDEF; exp_a[1] = 32'h01234567;
      exp_a[2] = 32'hFEDCBA98; exp_a[3] = 32'h76543210;
      bus.ready = 1'b1;
      push_row(row_a);
      check_eq("t1_count", 64'(count_o), 64'd1);
      for (int b = 0; b < 4; b++) begin
         check_eq($sformatf("t1_data_b%0d", b), 64'(bus.data), 64'(exp_a[b]));
         check_eq($sformatf("t1_last_b%0d", b), 64'(bus.last), 64'(b == 3));
         @(negedge clk);
      end
      check_eq("t1_idle", 64'(idle_o), 64'd1);
      check_eq("t1_valid_end", 64'(bus.valid), 64'd0);

      // Backpressure: ready pattern 1,0,0,1,0,0,...
      bus.ready = 1'b0;
      row_b = 128'h0F1E2D3C_4B5A6978_8796A5B4_C3D2E1F0;
      push_row(row_b);
      k = 0;
      for (int i = 0; i < 20 && k < 4; i++) begin
         check_eq($sformatf("t2_valid_i%0d", i), 64'(bus.valid), 64'd1);
         check_eq($sformatf("t2_data_i%0d", i), 64'(bus.data), 64'(row_b[k*32 +: 32]));
         check_eq($sformatf("t2_last_i%0d", i), 64'(bus.last), 64'(k == 3));
         check_eq($sformatf("t2_count_i%0d", i), 64'(count_o), 64'd1);
         bus.ready = (i % 3 == 0);
         @(negedge clk);
         if (bus.ready) k++;
      end
      check_eq("t2_beats_done", 64'(k), 64'd4);
      check_eq("t2_count_end", 64'(count_o), 64'd0);
      check_eq("t2_idle_end", 64'(idle_o), 64'd1);

      // Overflow: five rows into a four-deep FIFO with no drain
      bus.ready = 1'b0;
      for (int r = 1; r <= 4; r++) push_row(mk_row(r));
      check_eq("t3_count4", 64'(count_o), 64'd4);
      check_eq("t3_full", 64'(full_o), 64'd1);
      check_eq("t3_ovf_before", 64'(overflow_o), 64'd0);
      push_row(mk_row(5));
      check_eq("t3_count_after", 64'(count_o), 64'd4);
      check_eq("t3_ovf_set", 64'(overflow_o), 64'd1);
      bus.ready = 1'b1;
      for (int r = 1; r <= 4; r++) drain_row(mk_row(r), 4, $sformatf("t3_r%0d", r));
      check_eq("t3_valid_drained", 64'(bus.valid), 64'd0);
      check_eq("t3_ovf_sticky", 64'(overflow_o), 64'd1);
      clear_i = 1'b1;
      @(negedge clk);
      clear_i = 1'b0;
      check_eq("t3_ovf_cleared", 64'(overflow_o), 64'd0);

      // Full FIFO accepts a row when the head's last beat pops in the same cycle
      bus.ready = 1'b0;
      for (int r = 1; r <= 4; r++) push_row(mk_row(r));
      bus.ready = 1'b1;
      row_b = mk_row(1);
      for (int b = 0; b < 3; b++) begin
         check_eq($sformatf("t4_data_b%0d", b), 64'(bus.data), 64'(row_b[b*32 +: 32]));
         @(negedge clk);
      end
      check_eq("t4_last_pre", 64'(bus.last), 64'd1);
      check_eq("t4_full_pre", 64'(full_o), 64'd1);
      push_row(mk_row(5));
      check_eq("t4_count", 64'(count_o), 64'd4);
      check_eq("t4_full", 64'(full_o), 64'd1);
      check_eq("t4_ovf", 64'(overflow_o), 64'd0);
      for (int r = 2; r <= 5; r++) drain_row(mk_row(r), 4, $sformatf("t4_r%0d", r));
      check_eq("t4_idle", 64'(idle_o), 64'd1);

      // Two beats per row; the upper half of each row is never sent
      cfg_active_beats_i = 3'd2;
      @(negedge clk);
      bus.ready = 1'b0;
      for (int r = 1; r <= 3; r++) push_row(mk_row(r + 8));
      bus.ready = 1'b1;
      for (int r = 1; r <= 3; r++) drain_row(mk_row(r + 8), 2, $sformatf("t5_r%0d", r));
      check_eq("t5_valid_end", 64'(bus.valid), 64'd0);
      check_eq("t5_idle_end", 64'(idle_o), 64'd1);
      cfg_active_beats_i = 3'd7;
      @(negedge clk);
      push_row(row_a);
      drain_row(row_a, 4, "t5_clamp");
      check_eq("t5_clamp_idle", 64'(idle_o), 64'd1);
      cfg_active_beats_i = 3'd0;
      @(negedge clk);

      // Asynchronous reset mid-row with three rows stored
      bus.ready = 1'b0;
      for (int r = 1; r <= 3; r++) push_row(mk_row(r));
      bus.ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      check_eq("t6_pre_count", 64'(count_o), 64'd3);
      #2 nrst = 1'b0;
      #1 check_reset_state("t6_async");
      @(negedge clk);
      nrst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check_eq($sformatf("t6_quiet_%0d", i), 64'(bus.valid), 64'd0);
      end
      push_row(mk_row(6));
      drain_row(mk_row(6), 4, "t6_resume");

      // Flush coincident with a row write while full and overflowed
      bus.ready = 1'b0;
      for (int r = 1; r <= 5; r++) push_row(mk_row(r));
      check_eq("t7_ovf_pre", 64'(overflow_o), 64'd1);
      clear_i = 1'b1;
      push_row(mk_row(7));
      clear_i = 1'b0;
      check_eq("t7_count", 64'(count_o), 64'd0);
      check_eq("t7_idle", 64'(idle_o), 64'd1);
      check_eq("t7_ovf", 64'(overflow_o), 64'd0);
      check_eq("t7_valid", 64'(bus.valid), 64'd0);
      @(negedge clk);
      check_eq("t7_count_hold", 64'(count_o), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
